// File: rtl/sysu_modn_counter.sv
// -----------------------------------------------------------------------------
// sysu_modn_counter
//
// Presettable modulo-MOD up/down counter with a one-shot mode and a
// ripple-carry output for synchronous cascading.
//
// Parameters
//   WIDTH    counter width in bits (1..16)
//   modulus  set by the MOD parameter (2..2**WIDTH); Q always stays in 0..MOD-1
//
// Ports
//   CP       clock, all state changes on the rising edge
//   MR       asynchronous active-low master reset (Q=0, DONE=0)
//   PL       synchronous active-low parallel load (beats CE)
//   P        parallel load data, clamped to MOD-1 when out of range
//   CE       count enable, active-high
//   UD       direction: 1 = up, 0 = down
//   ONESHOT  1 = stop at the terminal value and raise DONE, 0 = wrap
//   Q        registered count value
//   TC       terminal count, combinational from Q and UD
//   RCO      ripple carry out = TC & CE & ~DONE, drives CE of the next stage
//   DONE     registered sticky flag: one-shot run has completed
// -----------------------------------------------------------------------------
module sysu_modn_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             PL,
    input  logic [WIDTH-1:0] P,
    input  logic             CE,
    input  logic             UD,
    input  logic             ONESHOT,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             RCO,
    output logic             DONE
);

    // Largest legal count value and the constants used around it.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(32'd0);
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             done_r;
    logic             done_next_s;
    logic             tc_s;

    // Terminal value for the current direction: MOD-1 going up, 0 going down.
    function automatic logic [WIDTH-1:0] terminal_value(input logic ud);
        logic [WIDTH-1:0] t;
        if (ud) begin
            t = MAX_VAL;
        end else begin
            t = ZERO_VAL;
        end
        return t;
    endfunction

    // Load value limited to the legal range. Compared one bit wider so the
    // test stays meaningful when MOD is a full power of two.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] v;
        if ({1'b0, p} > {1'b0, MAX_VAL}) begin
            v = MAX_VAL;
        end else begin
            v = p;
        end
        return v;
    endfunction

    // Increment with explicit wrap at MOD-1; for MOD = 2**WIDTH this is
    // identical to natural overflow.
    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] v;
        if (q == MAX_VAL) begin
            v = ZERO_VAL;
        end else begin
            v = q + ONE_VAL;
        end
        return v;
    endfunction

    // Decrement with explicit wrap from 0 back to MOD-1.
    function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] v;
        if (q == ZERO_VAL) begin
            v = MAX_VAL;
        end else begin
            v = q - ONE_VAL;
        end
        return v;
    endfunction

    // Terminal-count detect, follows UD without waiting for an edge.
    always_comb begin
        tc_s = (q_r == terminal_value(UD));
    end

    // Next-state selection: load beats count; a finished one-shot run
    // ignores CE until it is reloaded or reset.
    always_comb begin
        q_next_s    = q_r;
        done_next_s = done_r;
        if (!PL) begin
            q_next_s    = clamp_load(P);
            done_next_s = 1'b0;
        end else if (CE && !done_r) begin
            if (ONESHOT && tc_s) begin
                // Park on the terminal value and flag completion.
                q_next_s    = q_r;
                done_next_s = 1'b1;
            end else begin
                case (UD)
                    1'b1:    q_next_s = inc_wrap(q_r);
                    1'b0:    q_next_s = dec_wrap(q_r);
                    default: q_next_s = q_r;
                endcase
                done_next_s = done_r;
            end
        end else begin
            q_next_s    = q_r;
            done_next_s = done_r;
        end
    end

    // Count and one-shot state registers, cleared asynchronously by MR.
    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            q_r    <= ZERO_VAL;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            done_r <= done_next_s;
        end
    end

    // Output drive: Q and DONE straight from flops, TC/RCO combinational.
    always_comb begin
        Q    = q_r;
        DONE = done_r;
        TC   = tc_s;
        RCO  = tc_s & CE & ~done_r;
    end

endmodule
